// File: rtl/mips_pkg.sv
// Shared definitions for the program loader: loader FSM encoding and default widths.
package mips_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
//
// Handshake: the producer raises in_valid with in_data stable; a byte is
// transferred on a rising clk edge where in_valid and in_ready are both high.
// in_valid while in_ready is low transfers nothing. memwrite is a one-cycle
// strobe; adr/writedata are only meaningful while memwrite is high and
// otherwise hold their last values.
interface prog_loader_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  memwrite;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] writedata;

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, memwrite, adr, writedata
  );

  // Stream source / memory side.
  modport master (
    output in_valid, in_data,
    input  in_ready, memwrite, adr, writedata
  );

endinterface

// File: rtl/prog_loader.sv
// Program loader: receives length, payload and checksum bytes, writes the
// payload to memory from address 0, then releases the CPU or flags an error.
module prog_loader
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  prog_loader_if.slave   bus,
  output logic           loading,
  output logic           cpu_run,
  output logic           err,
  output state_t         dbg_state
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] length_q, length_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  memwrite_q, memwrite_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  in_ready;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] last_idx;

  // Length 0 wraps to all-ones here, which encodes a full 2^ADDR_WIDTH load.
  assign last_idx = length_q - ADDR_WIDTH'(1);
  assign accept   = bus.in_valid && in_ready;

  // State and datapath registers; reset wins over everything, including a pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      length_q   <= '0;
      ptr_q      <= '0;
      sum_q      <= '0;
      memwrite_q <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      ptr_q      <= ptr_d;
      sum_q      <= sum_d;
      memwrite_q <= memwrite_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    ptr_d      = ptr_q;
    sum_d      = sum_q;
    memwrite_d = 1'b0;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    in_ready   = 1'b0;
    loading    = 1'b0;
    cpu_run    = 1'b0;
    err        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        in_ready = 1'b1;
        loading  = 1'b1;
        if (accept) begin
          length_d = ADDR_WIDTH'(bus.in_data);
          ptr_d    = '0;
          sum_d    = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        loading  = 1'b1;
        if (accept) begin
          memwrite_d = 1'b1;
          adr_d      = ptr_q;
          wdata_d    = bus.in_data;
          sum_d      = sum_q + bus.in_data;
          // Pointer stops on the final byte so it never wraps within a load.
          if (ptr_q == last_idx) state_d = ST_CHK;
          else                   ptr_d   = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_CHK: begin
        in_ready = 1'b1;
        loading  = 1'b1;
        if (accept) state_d = (bus.in_data == sum_q) ? ST_RUN : ST_ERR;
      end
      ST_RUN: begin
        cpu_run = 1'b1;
        if (start) begin
          ptr_d   = '0;
          sum_d   = '0;
          state_d = ST_LEN;
        end
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) begin
          ptr_d   = '0;
          sum_d   = '0;
          state_d = ST_LEN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.memwrite  = memwrite_q;
  assign bus.adr       = adr_q;
  assign bus.writedata = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write scoreboard.
module tb_prog_loader;
  import mips_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  logic   loading, cpu_run, err;
  state_t dbg_state;

  always #5 clk = ~clk;

  prog_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  prog_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .loading   (loading),
    .cpu_run   (cpu_run),
    .err       (err),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_exp;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_byte(input logic [DW-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: byte %02h never accepted, required in_ready=1", b);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full good stream 03,11,22,33,66 starting from a state that accepts start.
  task automatic good_load();
    push_w(8'h00, 8'h11);
    push_w(8'h01, 8'h22);
    push_w(8'h02, 8'h33);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h66);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.memwrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got adr=%02h data=%02h, required no write",
                 bus.adr, bus.writedata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.adr, bus.writedata} !== mon_exp) begin
          errors++;
          $display("FAIL write_mismatch: got adr=%02h data=%02h, required adr=%02h data=%02h",
                   bus.adr, bus.writedata, mon_exp[AW+DW-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_memwrite", 32'(bus.memwrite), 0);
    chk("rst_adr", 32'(bus.adr), 0);
    chk("rst_writedata", 32'(bus.writedata), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_loading", 32'(loading), 0);
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // in_valid in IDLE consumes nothing
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(bus.in_ready), 0);
      chk("idle_loading", 32'(loading), 0);
      next_cycle();
    end
    bus.in_valid = 1'b0;

    // Basic load -> RUN
    good_load();
    @(negedge clk);
    chk("basic_cpu_run", 32'(cpu_run), 1);
    chk("basic_err", 32'(err), 0);
    chk("basic_loading", 32'(loading), 0);
    chk("basic_q_empty", 32'(exp_q.size()), 0);
    next_cycle();

    // Restart from RUN, bad checksum -> ERR
    pulse_start();
    @(negedge clk);
    chk("restart_cpu_run", 32'(cpu_run), 0);
    chk("restart_loading", 32'(loading), 1);
    chk("restart_state", 32'(dbg_state), 32'(ST_LEN));
    next_cycle();
    push_w(8'h00, 8'h11);
    push_w(8'h01, 8'h22);
    push_w(8'h02, 8'h33);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h67);
    @(negedge clk);
    chk("bad_err", 32'(err), 1);
    chk("bad_cpu_run", 32'(cpu_run), 0);
    chk("bad_loading", 32'(loading), 0);
    chk("bad_q_empty", 32'(exp_q.size()), 0);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("bad_err_hold", 32'(err), 1);
    next_cycle();

    // Start from ERR clears err next cycle, then good load 02,A0,0B,AB
    pulse_start();
    @(negedge clk);
    chk("err_clear", 32'(err), 0);
    chk("err_restart_state", 32'(dbg_state), 32'(ST_LEN));
    next_cycle();
    push_w(8'h00, 8'hA0);
    push_w(8'h01, 8'h0B);
    send_byte(8'h02);
    send_byte(8'hA0);
    send_byte(8'h0B);
    send_byte(8'hAB);
    @(negedge clk);
    chk("recover_cpu_run", 32'(cpu_run), 1);
    chk("recover_err", 32'(err), 0);
    next_cycle();

    // in_valid with bubbles during DATA: 04, 01..04, checksum 0A
    pulse_start();
    send_byte(8'h04);
    for (int i = 1; i <= 4; i++) begin
      push_w(AW'(i - 1), DW'(i));
      send_byte(DW'(i));
      next_cycle();
    end
    send_byte(8'h0A);
    @(negedge clk);
    chk("bubble_cpu_run", 32'(cpu_run), 1);
    chk("bubble_q_empty", 32'(exp_q.size()), 0);
    next_cycle();

    // start during DATA is ignored
    push_w(8'h00, 8'h11);
    push_w(8'h01, 8'h22);
    push_w(8'h02, 8'h33);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11);
    start = 1'b1;
    send_byte(8'h22);
    start = 1'b0;
    send_byte(8'h33);
    send_byte(8'h66);
    @(negedge clk);
    chk("startdata_cpu_run", 32'(cpu_run), 1);
    chk("startdata_state", 32'(dbg_state), 32'(ST_RUN));
    chk("startdata_q_empty", 32'(exp_q.size()), 0);
    next_cycle();

    // Length 00 -> full 256-byte load of 01, checksum 00
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      push_w(AW'(i), 8'h01);
      send_byte(8'h01);
    end
    send_byte(8'h00);
    @(negedge clk);
    chk("full_cpu_run", 32'(cpu_run), 1);
    chk("full_err", 32'(err), 0);
    chk("full_q_empty", 32'(exp_q.size()), 0);
    next_cycle();

    // Reset after the 2nd data byte
    push_w(8'h00, 8'h11);
    push_w(8'h01, 8'h22);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    reset        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    next_cycle();
    @(negedge clk);
    chk("midrst_memwrite", 32'(bus.memwrite), 0);
    chk("midrst_adr", 32'(bus.adr), 0);
    chk("midrst_writedata", 32'(bus.writedata), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    chk("midrst_loading", 32'(loading), 0);
    chk("midrst_cpu_run", 32'(cpu_run), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("midrst_q_empty", 32'(exp_q.size()), 0);
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_in_ready", 32'(bus.in_ready), 0);
      chk("postrst_state", 32'(dbg_state), 32'(ST_IDLE));
      next_cycle();
    end
    bus.in_valid = 1'b0;

    // Fresh load after reset
    good_load();
    @(negedge clk);
    chk("postrst_cpu_run", 32'(cpu_run), 1);
    next_cycle();

    // ---------------- report ----------------
    repeat (2) next_cycle();
    chk("final_q_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory data byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory address width; load length is counted in ADDR_WIDTH bits.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin or restart a program load.
REQ-006 SHALL have port in_valid, input, 1, meaning a byte is offered on in_data.
REQ-007 SHALL have port in_data, input, DATA_WIDTH, the offered stream byte.
REQ-008 SHALL have port in_ready, output, 1, meaning the loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-009 SHALL have port memwrite, output, 1, the memory write strobe toward external memory.
REQ-010 SHALL have port adr, output, ADDR_WIDTH, the memory write address.
REQ-011 SHALL have port writedata, output, DATA_WIDTH, the memory write data.
REQ-012 SHALL have port loading, output, 1, meaning memory port mux select: 1 = loader owns memory, 0 = CPU owns memory.
REQ-013 SHALL have port cpu_run, output, 1, meaning the CPU is released from reset.
REQ-014 SHALL have port err, output, 1, meaning a checksum mismatch occurred on the last load.

Function
REQ-015 SHALL implement the states IDLE, LEN, DATA, CHK, RUN and ERR.
REQ-016 In IDLE: in_ready=0, loading=0, cpu_run=0; start -> LEN.
REQ-017 In LEN: in_ready=1, loading=1; the accepted byte N is latched as the length, where N=0 means 2^ADDR_WIDTH bytes -> DATA; the pointer and checksum are cleared.
REQ-018 In DATA: in_ready=1; each accepted byte b registers memwrite=1, adr=ptr, writedata=b for exactly the next cycle.
REQ-019 In DATA: ptr increments after each accept, sum=(sum+b) mod 2^DATA_WIDTH, and back-to-back accepts give back-to-back write pulses.
REQ-020 After the Nth data byte is accepted -> CHK; the final write pulse still occurs in the first CHK cycle.
REQ-021 In CHK: in_ready=1; the accepted byte equal to sum -> RUN, otherwise -> ERR.
REQ-022 In RUN: loading=0 and cpu_run=1 from the first RUN cycle, with err=0.
REQ-023 In ERR: loading=0, cpu_run=0, err=1; err holds until reset or start.
REQ-024 start in RUN or ERR -> LEN in the next cycle, with cpu_run=0 and err=0 from that cycle.
REQ-025 start in LEN, DATA or CHK SHALL be ignored.
REQ-026 in_valid while in_ready=0 SHALL be ignored, with no byte consumed.
REQ-027 memwrite SHALL never be high outside the cycle after a DATA accept.
REQ-028 adr and writedata SHALL hold their last values when memwrite=0.
REQ-029 ptr SHALL never wrap within one load; the maximum adr is 2^ADDR_WIDTH-1.

Reset
REQ-030 reset low at a clock edge -> IDLE in the next cycle, including mid-load and mid-write; the pending memwrite is cancelled.
REQ-031 Reset values: memwrite=0, adr=0, writedata=0, in_ready=0, loading=0, cpu_run=0, err=0, ptr=0, sum=0, length=0.
REQ-032 reset SHALL take priority over start and over any handshake in the same cycle.

Structure
REQ-033 The state encoding and the DATA_WIDTH/ADDR_WIDTH defaults SHALL live in the shared package mips_pkg.
REQ-034 No sub-module is needed: one FSM plus ptr/length/sum registers; the memory-port mux belongs to the system top, selected by loading.

Verification
REQ-035 Stream start, then 03, 11, 22, 33, 66 -> writes 00<-11, 01<-22, 02<-33; cpu_run=1; err=0.
REQ-036 Same stream with checksum 67 -> three writes occur; err=1; cpu_run=0; then start plus a valid stream -> RUN.
REQ-037 Length 00 followed by 256 bytes of value 01 and checksum 00 -> writes to adr 00..FF; cpu_run=1.
REQ-038 in_valid toggled every other cycle during DATA -> one write per accepted byte only, with correct adr order.
REQ-039 reset low after the 2nd data byte -> memwrite=0 the next cycle, all outputs at reset values, and in_valid ignored until start.
REQ-040 start during DATA -> ignored; the load completes normally with the same writes as REQ-035.
